// File: rtl/cpu_pkg.sv
// Shared CPU types: ALU opcodes, forwarding selects and multiplier FSM states.
// Also holds the single-cycle ALU function used by the execute stage.
package cpu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100,
    ALU_NOR = 3'b101,
    ALU_XOR = 3'b110,
    ALU_MUL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

  // MUL is not a single-cycle op; it yields 0 here and is handled by the stage.
  function automatic logic [31:0] alu_calc(input alu_op_t op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {31'b0, ($signed(a) < $signed(b))};
      ALU_NOR: r = ~(a | b);
      ALU_XOR: r = a ^ b;
      default: r = 32'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Bundle between ID/EX + forwarding sources (master side) and the execute stage (slave).
// Flow control: ex_stall high means ID/EX, IF/ID and PC must hold; inputs stay stable until it drops.
interface ex_stage_if;
  logic [31:0] EXReg1;
  logic [31:0] EXReg2;
  logic [31:0] EXImmi;
  logic [4:0]  EXRegisterRs;
  logic [4:0]  EXRegisterRt;
  logic [4:0]  EXRegisterRd;
  logic [2:0]  EXALUOp;
  logic        EXALUSrc;
  logic        EXRegDst;
  logic        EXMemRead;
  logic        EXMemtoReg;
  logic        EXMemWrite;
  logic        EXRegWrite;
  logic        MEMRegWrite;
  logic [4:0]  MEMRegisterRd;
  logic [31:0] MEMALUResult;
  logic        WBRegWrite;
  logic [4:0]  WBRegisterRd;
  logic [31:0] WBWriteData;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dest_reg;
  logic        ex_zero;
  logic        ex_mem_read;
  logic        ex_mem_to_reg;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_stall;

  modport master (
    output EXReg1, EXReg2, EXImmi, EXRegisterRs, EXRegisterRt, EXRegisterRd, EXALUOp,
           EXALUSrc, EXRegDst, EXMemRead, EXMemtoReg, EXMemWrite, EXRegWrite,
           MEMRegWrite, MEMRegisterRd, MEMALUResult, WBRegWrite, WBRegisterRd, WBWriteData,
    input  ex_alu_result, ex_store_data, ex_dest_reg, ex_zero, ex_mem_read,
           ex_mem_to_reg, ex_mem_write, ex_reg_write, ex_stall
  );

  modport slave (
    input  EXReg1, EXReg2, EXImmi, EXRegisterRs, EXRegisterRt, EXRegisterRd, EXALUOp,
           EXALUSrc, EXRegDst, EXMemRead, EXMemtoReg, EXMemWrite, EXRegWrite,
           MEMRegWrite, MEMRegisterRd, MEMALUResult, WBRegWrite, WBRegisterRd, WBWriteData,
    output ex_alu_result, ex_store_data, ex_dest_reg, ex_zero, ex_mem_read,
           ex_mem_to_reg, ex_mem_write, ex_reg_write, ex_stall
  );
endinterface

// File: rtl/forward_unit.sv
// Combinational rs/rt forwarding select; EX/MEM has priority over MEM/WB, $zero never forwards.
module forward_unit
  import cpu_pkg::*;
(
  input  logic       i_mem_reg_write,
  input  logic [4:0] i_mem_rd,
  input  logic       i_wb_reg_write,
  input  logic [4:0] i_wb_rd,
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rt,
  output fwd_sel_t   o_sel_a,
  output fwd_sel_t   o_sel_b
);

  function automatic fwd_sel_t pick(input logic mem_we, input logic [4:0] mem_rd,
                                    input logic wb_we, input logic [4:0] wb_rd,
                                    input logic [4:0] src);
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) return FWD_MEM;
    else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) return FWD_WB;
    else return FWD_REG;
  endfunction

  assign o_sel_a = pick(i_mem_reg_write, i_mem_rd, i_wb_reg_write, i_wb_rd, i_rs);
  assign o_sel_b = pick(i_mem_reg_write, i_mem_rd, i_wb_reg_write, i_wb_rd, i_rt);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU and an optional iterative MUL.
// The MUL FSM/datapath exists only when EX_MUL_EN is defined; otherwise MUL yields 0, no stall.
module ex_stage
  import cpu_pkg::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.slave  bus,
  output mul_state_t o_dbg_state
);

  fwd_sel_t    w_sel_a, w_sel_b;
  logic [31:0] w_fwd_a, w_fwd_b, w_op_b, w_alu, w_result;
  logic        w_stall;

  forward_unit u_fwd (
    .i_mem_reg_write (bus.MEMRegWrite),
    .i_mem_rd        (bus.MEMRegisterRd),
    .i_wb_reg_write  (bus.WBRegWrite),
    .i_wb_rd         (bus.WBRegisterRd),
    .i_rs            (bus.EXRegisterRs),
    .i_rt            (bus.EXRegisterRt),
    .o_sel_a         (w_sel_a),
    .o_sel_b         (w_sel_b)
  );

  always_comb begin
    w_fwd_a = bus.EXReg1;
    w_fwd_b = bus.EXReg2;
    case (w_sel_a)
      FWD_MEM: w_fwd_a = bus.MEMALUResult;
      FWD_WB:  w_fwd_a = bus.WBWriteData;
      default: w_fwd_a = bus.EXReg1;
    endcase
    case (w_sel_b)
      FWD_MEM: w_fwd_b = bus.MEMALUResult;
      FWD_WB:  w_fwd_b = bus.WBWriteData;
      default: w_fwd_b = bus.EXReg2;
    endcase
  end

  assign w_op_b = bus.EXALUSrc ? bus.EXImmi : w_fwd_b;
  assign w_alu  = alu_calc(alu_op_t'(bus.EXALUOp), w_fwd_a, w_op_b);

`ifdef EX_MUL_EN
  localparam int          STEPS      = 32 / MUL_BITS_PER_CYCLE;
  localparam logic [31:0] DIGIT_MASK = 32'((64'd1 << MUL_BITS_PER_CYCLE) - 64'd1);

  mul_state_t  r_state, w_next;
  logic [31:0] r_acc, r_mcand, r_mplier;
  logic [4:0]  r_cnt;
  logic [31:0] w_partial;

  assign w_partial = r_mcand * (r_mplier & DIGIT_MASK);

  always_comb begin
    w_next   = r_state;
    w_stall  = 1'b0;
    w_result = w_alu;
    case (r_state)
      IDLE: begin
        if (alu_op_t'(bus.EXALUOp) == ALU_MUL) begin
          w_stall = 1'b1;
          w_next  = MUL_RUN;
        end
      end
      MUL_RUN: begin
        w_stall = 1'b1;
        if (r_cnt == 5'd0) w_next = MUL_DONE;
      end
      MUL_DONE: begin
        w_result = r_acc;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operands are captured at issue: the forwarding sources keep moving while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= 32'b0;
      r_mcand  <= 32'b0;
      r_mplier <= 32'b0;
      r_cnt    <= 5'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == MUL_RUN) begin
        r_acc    <= 32'b0;
        r_mcand  <= w_fwd_a;
        r_mplier <= w_fwd_b;
        r_cnt    <= 5'(STEPS - 1);
      end else if (r_state == MUL_RUN) begin
        r_acc    <= r_acc + w_partial;
        r_mcand  <= r_mcand << MUL_BITS_PER_CYCLE;
        r_mplier <= r_mplier >> MUL_BITS_PER_CYCLE;
        r_cnt    <= r_cnt - 5'd1;
      end
    end
  end

  assign o_dbg_state = r_state;
`else
  logic w_unused;
  assign w_unused    = clk ^ rst;
  assign w_stall     = 1'b0;
  assign w_result    = w_alu;
  assign o_dbg_state = IDLE;
`endif

  assign bus.ex_alu_result = w_result;
  assign bus.ex_zero       = (w_result == 32'b0);
  assign bus.ex_store_data = w_fwd_b;
  assign bus.ex_dest_reg   = bus.EXRegDst ? bus.EXRegisterRd : bus.EXRegisterRt;
  assign bus.ex_mem_read   = bus.EXMemRead  & ~w_stall;
  assign bus.ex_mem_write  = bus.EXMemWrite & ~w_stall;
  assign bus.ex_reg_write  = bus.EXRegWrite & ~w_stall;
  assign bus.ex_mem_to_reg = bus.EXMemtoReg;
  assign bus.ex_stall      = w_stall;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: a default-radix instance plus a 4-bits-per-cycle instance.
// MUL scenarios are exercised when EX_MUL_EN is defined; otherwise the disabled-MUL behaviour is checked.
module tb_ex_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        sel4 = 1'b0;
  logic [31:0] d_reg1, d_reg2, d_imm, d_mem_res, d_wb_data;
  logic [4:0]  d_rs, d_rt, d_rd, d_mem_rd, d_wb_rd;
  logic [2:0]  d_op;
  logic        d_alusrc, d_regdst, d_mrd, d_m2r, d_mwr, d_rw, d_mem_rw, d_wb_rw;

  ex_stage_if bus1 ();
  ex_stage_if bus4 ();
  mul_state_t st1, st4;

  ex_stage #(.MUL_BITS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave), .o_dbg_state(st1));
  ex_stage #(.MUL_BITS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave), .o_dbg_state(st4));

  assign bus1.EXALUOp = sel4 ? 3'b000 : d_op;
  assign bus4.EXALUOp = sel4 ? d_op : 3'b000;
  assign bus1.EXReg1 = d_reg1;         assign bus4.EXReg1 = d_reg1;
  assign bus1.EXReg2 = d_reg2;         assign bus4.EXReg2 = d_reg2;
  assign bus1.EXImmi = d_imm;          assign bus4.EXImmi = d_imm;
  assign bus1.EXRegisterRs = d_rs;     assign bus4.EXRegisterRs = d_rs;
  assign bus1.EXRegisterRt = d_rt;     assign bus4.EXRegisterRt = d_rt;
  assign bus1.EXRegisterRd = d_rd;     assign bus4.EXRegisterRd = d_rd;
  assign bus1.EXALUSrc = d_alusrc;     assign bus4.EXALUSrc = d_alusrc;
  assign bus1.EXRegDst = d_regdst;     assign bus4.EXRegDst = d_regdst;
  assign bus1.EXMemRead = d_mrd;       assign bus4.EXMemRead = d_mrd;
  assign bus1.EXMemtoReg = d_m2r;      assign bus4.EXMemtoReg = d_m2r;
  assign bus1.EXMemWrite = d_mwr;      assign bus4.EXMemWrite = d_mwr;
  assign bus1.EXRegWrite = d_rw;       assign bus4.EXRegWrite = d_rw;
  assign bus1.MEMRegWrite = d_mem_rw;  assign bus4.MEMRegWrite = d_mem_rw;
  assign bus1.MEMRegisterRd = d_mem_rd; assign bus4.MEMRegisterRd = d_mem_rd;
  assign bus1.MEMALUResult = d_mem_res; assign bus4.MEMALUResult = d_mem_res;
  assign bus1.WBRegWrite = d_wb_rw;    assign bus4.WBRegWrite = d_wb_rw;
  assign bus1.WBRegisterRd = d_wb_rd;  assign bus4.WBRegisterRd = d_wb_rd;
  assign bus1.WBWriteData = d_wb_data; assign bus4.WBWriteData = d_wb_data;

  logic [31:0] o_result, o_store;
  logic [4:0]  o_dest;
  logic        o_zero, o_stall;
  logic [3:0]  o_ctrl;   // {mem_read, mem_write, reg_write, mem_to_reg}
  mul_state_t  o_state;

  assign o_result = sel4 ? bus4.ex_alu_result : bus1.ex_alu_result;
  assign o_store  = sel4 ? bus4.ex_store_data : bus1.ex_store_data;
  assign o_dest   = sel4 ? bus4.ex_dest_reg   : bus1.ex_dest_reg;
  assign o_zero   = sel4 ? bus4.ex_zero       : bus1.ex_zero;
  assign o_stall  = sel4 ? bus4.ex_stall      : bus1.ex_stall;
  assign o_state  = sel4 ? st4 : st1;
  assign o_ctrl   = sel4 ? {bus4.ex_mem_read, bus4.ex_mem_write, bus4.ex_reg_write, bus4.ex_mem_to_reg}
                         : {bus1.ex_mem_read, bus1.ex_mem_write, bus1.ex_reg_write, bus1.ex_mem_to_reg};

  task automatic set_bubble();
    d_reg1 = 0; d_reg2 = 0; d_imm = 0; d_mem_res = 0; d_wb_data = 0;
    d_rs = 0; d_rt = 0; d_rd = 0; d_mem_rd = 0; d_wb_rd = 0; d_op = 3'b000;
    d_alusrc = 0; d_regdst = 0; d_mrd = 0; d_m2r = 0; d_mwr = 0; d_rw = 0;
    d_mem_rw = 0; d_wb_rw = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_bubble();
    repeat (3) @(negedge clk);
    total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
    total++; if (o_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", o_state, IDLE); end
    total++; if (o_result !== 32'd0 || o_zero !== 1'b1) begin bad++; $display("FAIL reset_result got=%h/%b exp=0/1", o_result, o_zero); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alu();
    logic [2:0]  ops [10] = '{3'b000, 3'b001, 3'b100, 3'b100, 3'b101, 3'b000, 3'b010, 3'b011, 3'b110, 3'b001};
    logic [31:0] as  [10] = '{32'd5, 32'd9, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h7FFFFFFF, 32'hF0F01234, 32'h00FF0000, 32'hFFFF0000, 32'd0};
    logic [31:0] bs  [10] = '{32'd7, 32'd9, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd1, 32'h0FF0FFFF, 32'h000000FF, 32'hFF00FF00, 32'd1};
    logic [31:0] exs [10] = '{32'd12, 32'd0, 32'd1, 32'd0, 32'hFFFFFFFF, 32'h80000000, 32'h00F01234, 32'h00FF00FF, 32'h00FFFF00, 32'hFFFFFFFF};
    set_bubble();
    d_rs = 5'd1; d_rt = 5'd2;
    for (int i = 0; i < 10; i++) begin
      d_op = ops[i]; d_reg1 = as[i]; d_reg2 = bs[i];
      #1;
      total++;
      if (o_result !== exs[i] || o_zero !== (exs[i] == 32'd0) || o_stall !== 1'b0) begin
        bad++; $display("FAIL alu_vec%0d got=%h z=%b s=%b exp=%h", i, o_result, o_zero, o_stall, exs[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_forward();
    set_bubble();
    d_rs = 5'd3; d_rt = 5'd4; d_reg1 = 32'd20; d_reg2 = 32'd30; d_alusrc = 1'b1; d_imm = 32'd1;
    d_mem_rw = 1; d_mem_rd = 5'd3; d_mem_res = 32'd100;
    d_wb_rw = 1; d_wb_rd = 5'd3; d_wb_data = 32'd50;
    #1; total++; if (o_result !== 32'd101 || o_store !== 32'd30) begin bad++; $display("FAIL fwd_mem_priority got=%0d st=%0d exp=101 st=30", o_result, o_store); end
    d_mem_rd = 5'd0;
    #1; total++; if (o_result !== 32'd51) begin bad++; $display("FAIL fwd_mem_rd0 got=%0d exp=51", o_result); end
    d_wb_rd = 5'd0;
    #1; total++; if (o_result !== 32'd21) begin bad++; $display("FAIL fwd_none got=%0d exp=21", o_result); end
    d_mem_rw = 0; d_mem_rd = 5'd3; d_wb_rd = 5'd3;
    #1; total++; if (o_result !== 32'd51) begin bad++; $display("FAIL fwd_wb got=%0d exp=51", o_result); end
    d_mem_rw = 1; d_mem_rd = 5'd4; d_wb_rd = 5'd4; d_alusrc = 1'b0;
    #1; total++; if (o_store !== 32'd100 || o_result !== 32'd120) begin bad++; $display("FAIL fwd_rt_mem got=%0d st=%0d exp=120 st=100", o_result, o_store); end
    d_mem_rw = 0;
    #1; total++; if (o_store !== 32'd50 || o_result !== 32'd70) begin bad++; $display("FAIL fwd_rt_wb got=%0d st=%0d exp=70 st=50", o_result, o_store); end
    d_rd = 5'd9; d_regdst = 1'b1;
    #1; total++; if (o_dest !== 5'd9) begin bad++; $display("FAIL dest_rd got=%0d exp=9", o_dest); end
    d_regdst = 1'b0;
    #1; total++; if (o_dest !== 5'd4) begin bad++; $display("FAIL dest_rt got=%0d exp=4", o_dest); end
    @(negedge clk);
  endtask

  task automatic test_controls();
    set_bubble();
    d_mrd = 1; d_mwr = 0; d_rw = 1; d_m2r = 1;
    #1; total++; if (o_ctrl !== 4'b1011) begin bad++; $display("FAIL ctrl_pass_a got=%b exp=1011", o_ctrl); end
    d_mrd = 0; d_mwr = 1; d_rw = 0; d_m2r = 0;
    #1; total++; if (o_ctrl !== 4'b0100) begin bad++; $display("FAIL ctrl_pass_b got=%b exp=0100", o_ctrl); end
    @(negedge clk);
  endtask

`ifdef EX_MUL_EN
  // Operand A arrives via EX/MEM forwarding; the sources are disturbed mid-stall.
  task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_cycles);
    int cyc;
    @(negedge clk);
    d_op = 3'b111; d_rs = 5'd3; d_rt = 5'd4; d_reg1 = 32'hDEADBEEF; d_reg2 = b; d_alusrc = 0;
    d_mem_rw = 1; d_mem_rd = 5'd3; d_mem_res = a; d_wb_rw = 0; d_wb_rd = 0; d_wb_data = 0;
    d_mrd = 1; d_mwr = 1; d_rw = 1; d_m2r = 1;
    #1;
    cyc = 0;
    while (o_stall === 1'b1 && cyc < 100) begin
      cyc++;
      total++; if (o_ctrl !== 4'b0001) begin bad++; $display("FAIL %s_gated cyc=%0d got=%b exp=0001", name, cyc, o_ctrl); end
      if (cyc == 3) begin d_mem_res = ~a; d_wb_rw = 1; d_wb_rd = 5'd4; d_wb_data = 32'd999; end
      @(negedge clk);
    end
    total++; if (cyc != exp_cycles) begin bad++; $display("FAIL %s_stall_cycles got=%0d exp=%0d", name, cyc, exp_cycles); end
    total++; if (o_result !== exp_res) begin bad++; $display("FAIL %s_result got=%h exp=%h", name, o_result, exp_res); end
    total++; if (o_ctrl !== 4'b1111 || o_state !== MUL_DONE) begin bad++; $display("FAIL %s_done got=%b st=%0d exp=1111 st=%0d", name, o_ctrl, o_state, MUL_DONE); end
  endtask

  task automatic test_mul();
    sel4 = 1'b0;
    run_mul("mul_6x7", 32'd6, 32'd7, 32'd42, 33);
  endtask

  task automatic test_back_to_back();
    run_mul("mul_b2b", 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 33);
  endtask

  task automatic test_mul_radix4();
    sel4 = 1'b1;
    run_mul("mul_r4", 32'h00010003, 32'h00000123, 32'h01230369, 9);
    @(negedge clk);
    set_bubble();
    sel4 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    set_bubble();
    d_op = 3'b111; d_reg1 = 32'd6; d_reg2 = 32'd7; d_rs = 5'd1; d_rt = 5'd2;
    repeat (5) @(negedge clk);
    total++; if (o_stall !== 1'b1 || o_state !== MUL_RUN) begin bad++; $display("FAIL midrst_running got=%b st=%0d exp=1 st=%0d", o_stall, o_state, MUL_RUN); end
    rst = 1'b1;
    set_bubble();
    @(negedge clk);
    total++; if (o_stall !== 1'b0 || o_state !== IDLE) begin bad++; $display("FAIL midrst_abort got=%b st=%0d exp=0 st=%0d", o_stall, o_state, IDLE); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (o_stall !== 1'b0 || o_state !== IDLE || o_result !== 32'd0) begin bad++; $display("FAIL midrst_after got=%b st=%0d r=%h exp=0 idle 0", o_stall, o_state, o_result); end
  endtask
`else
  task automatic test_mul_disabled();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      sel4 = (k == 1);
      set_bubble();
      d_op = 3'b111; d_reg1 = 32'd6; d_reg2 = 32'd7; d_rs = 5'd1; d_rt = 5'd2;
      d_mrd = 1; d_mwr = 1; d_rw = 1; d_m2r = 1;
      #1;
      total++; if (o_result !== 32'd0 || o_zero !== 1'b1) begin bad++; $display("FAIL nomul_result%0d got=%h exp=0", k, o_result); end
      total++; if (o_stall !== 1'b0 || o_ctrl !== 4'b1111) begin bad++; $display("FAIL nomul_ctrl%0d got=%b/%b exp=0/1111", k, o_stall, o_ctrl); end
      repeat (2) @(negedge clk);
      total++; if (o_stall !== 1'b0 || o_state !== IDLE) begin bad++; $display("FAIL nomul_idle%0d got=%b st=%0d exp=0 idle", k, o_stall, o_state); end
    end
    sel4 = 1'b0;
    set_bubble();
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_forward();
    test_controls();
`ifdef EX_MUL_EN
    test_mul();
    test_back_to_back();
    test_mul_radix4();
    test_reset_mid_mul();
`else
    test_mul_disabled();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage placed directly downstream of the ID/EX pipeline register, upstream of EX/MEM.
- Resolves operand forwarding from EX/MEM and MEM/WB, then executes single-cycle ALU ops.
- Executes a multi-cycle iterative MUL, raising `ex_stall` to freeze PC, IF/ID and ID/EX until the product is ready.
- Produces the ALU result, store data, destination register and control bits for EX/MEM.

Parameters:
- MUL_BITS_PER_CYCLE, default 1: multiplier bits retired per cycle. Legal values are 1, 2 and 4. MUL iteration count is 32/MUL_BITS_PER_CYCLE.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- EXReg1, EXReg2  in  32  rs/rt read data from ID/EX
- EXImmi  in  32  sign-extended immediate
- EXRegisterRs, EXRegisterRt, EXRegisterRd  in  5  register numbers
- EXALUOp  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 NOR, 110 XOR, 111 MUL
- EXALUSrc, EXRegDst, EXMemRead, EXMemtoReg, EXMemWrite, EXRegWrite  in  1  control bits
- MEMRegWrite  in  1  EX/MEM stage write enable
- MEMRegisterRd  in  5  EX/MEM stage destination register
- MEMALUResult  in  32  EX/MEM stage result
- WBRegWrite  in  1  MEM/WB stage write enable
- WBRegisterRd  in  5  MEM/WB stage destination register
- WBWriteData  in  32  MEM/WB stage write data
- ex_alu_result  out  32  result to EX/MEM
- ex_store_data  out  32  forwarded rt value
- ex_dest_reg  out  5  `EXRegDst ? EXRegisterRd : EXRegisterRt`
- ex_zero  out  1  `ex_alu_result == 0`
- ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_reg_write  out  1  gated control bits to EX/MEM
- ex_stall  out  1  freeze request to PC, IF/ID and ID/EX

Behaviour:
- Forwarding for operand A (rs):
  - EX/MEM wins when `MEMRegWrite && MEMRegisterRd != 0 && MEMRegisterRd == EXRegisterRs`.
  - Otherwise MEM/WB is used under the same condition with the WB signals.
  - Otherwise EXReg1 is used.
- Forwarding for rt: same rule with EXRegisterRt, giving fwd_b.
  - `ex_store_data = fwd_b`.
  - `op_b = EXALUSrc ? EXImmi : fwd_b`.
- Single-cycle ops (combinational, same cycle):
  - Arithmetic is 32-bit wrap-around; no overflow trap.
  - SLT is signed and returns 0 or 1.
- FSM states: IDLE, MUL_RUN, MUL_DONE.
  - IDLE with `EXALUOp == 111`:
    - `ex_stall = 1` combinationally in the same cycle.
    - Forwarded A and B are latched into multiplicand/multiplier registers; accumulator is cleared; step counter is loaded with `32/MUL_BITS_PER_CYCLE - 1`.
    - Next state is MUL_RUN.
  - MUL_RUN, each cycle:
    - Accumulator += multiplicand × (low MUL_BITS_PER_CYCLE multiplier bits).
    - Multiplicand shifts left and multiplier shifts right by MUL_BITS_PER_CYCLE.
    - Counter decrements.
    - `ex_stall = 1`.
    - Counter == 0 → MUL_DONE.
  - MUL_DONE:
    - `ex_stall = 0`; `ex_alu_result` = accumulator (low 32 bits of the product, sign-agnostic).
    - Next state is IDLE unconditionally; ID/EX advances on this edge.
    - Back-to-back MULs restart from IDLE on the following cycle.
- Operands are latched at issue because the MEM and WB forwarding sources keep moving while the stage is stalled.
- While `ex_stall = 1`, the gated controls `ex_mem_read`, `ex_mem_write` and `ex_reg_write` are forced to 0, so a bubble enters EX/MEM. `ex_mem_to_reg` passes through.
- Latency:
  - Non-MUL ops take 0 extra cycles.
  - MUL holds stall for 32/MUL_BITS_PER_CYCLE + 1 cycles, then delivers the result in the MUL_DONE cycle.
  - With MUL_BITS_PER_CYCLE = 1: 33 stall cycles.
- Reset values:
  - State IDLE; accumulator, multiplicand, multiplier and counter = 0.
  - `ex_stall = 0`.
  - Combinational outputs follow their inputs.
- Reset during MUL_RUN aborts to IDLE next edge; no partial result is visible.
- An all-zero bubble in ID/EX (ADD, no writes) is harmless; MUL never starts from a bubble.

Optional Feature:
- Macro: EX_MUL_EN
- Defined: the MUL FSM and datapath above are present.
- Undefined:
  - FSM and multiplier registers are not instantiated.
  - `ex_stall` is tied 0.
  - `EXALUOp == 111` yields `ex_alu_result = 0`, with controls passed through ungated.

Decomposition:
- Shared package `cpu_pkg`: ALUOp encodings (ALU_ADD..ALU_MUL), forwarding select enum (FWD_REG, FWD_MEM, FWD_WB), `mul_state_t` enum.
- Sub-module `forward_unit`: combinational rs/rt select generation, reused by a later branch-in-ID forwarding path.
- ALU and multiplier stay in `ex_stage`.

Test Plan:
- ADD with `EXReg1 = 5`, `EXReg2 = 7`, ALUSrc = 0 → `ex_alu_result = 12`, `ex_zero = 0`, `ex_stall = 0`. SUB of 9 − 9 → `ex_zero = 1`.
- rs = 3 with `MEMRegWrite = 1`, `MEMRegisterRd = 3`, `MEMALUResult = 100`, and also `WBRegisterRd = 3`, `WBWriteData = 50`; ADD imm 1 → result 101 (EX/MEM priority). Same setup with Rd = 0 → uses EXReg1.
- SLT with A = 0xFFFFFFFF, B = 1 → 1. NOR 0, 0 → 0xFFFFFFFF. ADD 0x7FFFFFFF + 1 → 0x80000000 (wrap, no trap).
- MUL with 6 × 7, default parameter → `ex_stall` high for exactly 33 cycles with gated controls 0, then result 42 for one cycle. Back-to-back second MUL with 0xFFFFFFFF × 2 → 0xFFFFFFFE.
- Forwarding sources change during a MUL stall → result unchanged, proving operand latch. MUL_BITS_PER_CYCLE = 4 → 9 stall cycles.
- Assert `rst` mid-MUL_RUN → next cycle state IDLE, `ex_stall = 0`. Build without EX_MUL_EN → ALUOp 111 gives 0 and no stall.
